// File: rtl/nt_display_pkg.sv
// Shared text-terminal display parameters and the row-fetch FSM state type.
// Pure declarations: no timing or flow-control behaviour.
package nt_display_pkg;
   localparam int CORDW   = 32;
   localparam int V_RES   = 480;
   localparam int COLS    = 80;
   localparam int ROWS    = 30;
   localparam int CHAR_H  = 16;
   localparam int CHARW   = 8;
   localparam int ADDRW   = 12;
   localparam int COLW    = 7;
   localparam int CH_LOG2 = $clog2(CHAR_H);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fsm_t;
endpackage

// File: rtl/line_buf_dp.sv
// Two-half character line buffer: one write port, one read port.
// Read data is registered (1-cycle latency); no backpressure on either port.
module line_buf_dp
   import nt_display_pkg::*;
(
   input  logic             clk_pix,
   input  logic             rst_pix_n,
   input  logic             i_we,
   input  logic             i_wsel,
   input  logic [COLW-1:0]  i_wcol,
   input  logic [CHARW-1:0] i_wdat,
   input  logic             i_rsel,
   input  logic [COLW-1:0]  i_rcol,
   output logic [CHARW-1:0] o_rdat
);
   localparam int LBW = $clog2(2*COLS);

   logic [CHARW-1:0] r_mem [0:2*COLS-1];
   logic [LBW-1:0]   w_waddr;
   logic [LBW-1:0]   w_raddr;
   logic             w_rcol_ok;

   // Half select picks the upper or lower COLS entries.
   assign w_waddr   = i_wsel ? LBW'(COLS) + LBW'(i_wcol) : LBW'(i_wcol);
   assign w_raddr   = i_rsel ? LBW'(COLS) + LBW'(i_rcol) : LBW'(i_rcol);
   assign w_rcol_ok = (i_rcol < COLW'(COLS));

   always_ff @(posedge clk_pix) begin
      if (i_we) r_mem[w_waddr] <= i_wdat;
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) o_rdat <= '0;
      else            o_rdat <= w_rcol_ok ? r_mem[w_raddr] : '0;
   end
endmodule

// File: rtl/text_row_fetcher.sv
// Row-ahead scheduler sharing one text RAM between scanout prefetch and host writes.
// A row fetch takes COLS+1 cycles; host writes stall (wr_ready=0) while a fetch owns the RAM.
module text_row_fetcher
   import nt_display_pkg::*;
(
   input  logic                    clk_pix,
   input  logic                    rst_pix_n,
   input  logic                    line,
   input  logic signed [CORDW-1:0] sy,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [ADDRW-1:0]        wr_addr,
   input  logic [CHARW-1:0]        wr_data,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [ADDRW-1:0]        ram_addr,
   output logic [CHARW-1:0]        ram_wdata,
   input  logic [CHARW-1:0]        ram_rdata,
   input  logic [COLW-1:0]         lb_col,
   output logic [CHARW-1:0]        lb_char,
   output logic                    busy,
   output logic                    err_underrun
);
   fsm_t                    r_state, w_next;
   logic                    r_front, r_pending, r_run, r_cap_vld;
   logic [COLW-1:0]         r_col, r_cap_col;
   logic [ADDRW-1:0]        r_base;
   logic signed [CORDW-1:0] w_n;
   logic                    w_trig, w_first, w_busy, w_swap, w_last, w_wr_acc, w_fetch;

   assign w_n     = sy + CORDW'(1);
   assign w_trig  = line && (w_n >= 0) && (w_n <= CORDW'(V_RES-1)) && (w_n[CH_LOG2-1:0] == '0);
   assign w_first = (w_n == '0);
   assign w_busy  = (r_state != IDLE);
   assign w_swap  = line && (r_pending || w_busy);
   assign w_last  = (r_col == COLW'(COLS-1));
   assign w_fetch = (r_state == FETCH);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = IDLE;
         FETCH:   if (w_last) w_next = DRAIN;
         DRAIN:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_swap && w_busy) w_next = IDLE;
      // A fresh trigger restarts the fetch into the half that just became back.
      if (w_trig) w_next = FETCH;
   end

   // r_run keeps wr_ready low while reset is asserted.
   always_comb begin
      wr_ready  = r_run && (r_state == IDLE) && !w_trig;
      w_wr_acc  = wr_valid && wr_ready;
      ram_en    = w_fetch || w_wr_acc;
      ram_we    = w_wr_acc;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_fetch) begin
         ram_addr = r_base + ADDRW'(r_col);
      end else if (w_wr_acc) begin
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end
   end

   assign busy         = w_busy;
   assign err_underrun = w_swap && w_busy;

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         r_state   <= IDLE;
         r_front   <= 1'b0;
         r_pending <= 1'b0;
         r_run     <= 1'b0;
         r_col     <= '0;
         r_base    <= '0;
         r_cap_vld <= 1'b0;
         r_cap_col <= '0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
         if (w_swap) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
         end else if (r_state == DRAIN) begin
            r_pending <= 1'b1;
         end
         if (w_trig) begin
            r_col  <= '0;
            r_base <= w_first ? '0 : r_base + ADDRW'(COLS);
         end else if (w_fetch) begin
            r_col <= r_col + 1'b1;
         end
         // Data returning after an abort belongs to a dropped row; never let it land.
         r_cap_vld <= w_fetch && !w_swap;
         r_cap_col <= r_col;
      end
   end

   line_buf_dp u_line_buf (
      .clk_pix   (clk_pix),
      .rst_pix_n (rst_pix_n),
      .i_we      (r_cap_vld && !w_swap),
      .i_wsel    (~r_front),
      .i_wcol    (r_cap_col),
      .i_wdat    (ram_rdata),
      .i_rsel    (r_front),
      .i_rcol    (lb_col),
      .o_rdat    (lb_char)
   );
endmodule

// File: tb/tb_text_row_fetcher.sv
// Bench for text_row_fetcher: behavioural text RAM, scoreboarded fetch addresses and host writes.
module tb_text_row_fetcher;
   import nt_display_pkg::*;

   logic                    clk_pix = 1'b0;
   logic                    rst_pix_n = 1'b0;
   logic                    line = 1'b0;
   logic signed [CORDW-1:0] sy = '0;
   logic                    wr_valid = 1'b0;
   logic                    wr_ready;
   logic [ADDRW-1:0]        wr_addr = '0;
   logic [CHARW-1:0]        wr_data = '0;
   logic                    ram_en, ram_we;
   logic [ADDRW-1:0]        ram_addr;
   logic [CHARW-1:0]        ram_wdata;
   logic [CHARW-1:0]        ram_rdata = '0;
   logic [COLW-1:0]         lb_col = '0;
   logic [CHARW-1:0]        lb_char;
   logic                    busy, err_underrun;

   int n_cmp = 0;
   int n_mis = 0;
   int err_cnt = 0;
   int wr_cnt = 0;
   int acc;
   logic [ADDRW-1:0]       exp_rd_q[$];
   logic [ADDRW+CHARW-1:0] exp_wr_q[$];
   logic [CHARW-1:0]       ram [0:(1<<ADDRW)-1];

   text_row_fetcher dut (
      .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .line(line), .sy(sy),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .lb_col(lb_col), .lb_char(lb_char),
      .busy(busy), .err_underrun(err_underrun)
   );

   always #5 clk_pix = ~clk_pix;

   function automatic logic [CHARW-1:0] gold(input int a);
      return CHARW'((a * 37 + 11) & 255);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial for (int i = 0; i < (1 << ADDRW); i++) ram[i] = gold(i);

   always @(posedge clk_pix) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else        ram_rdata     <= ram[ram_addr];
      end
   end

   always @(negedge clk_pix) begin
      if (err_underrun) err_cnt++;
      if (ram_en && !ram_we) begin
         if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(ram_addr), 32'hFFFF);
         else                      check("rd_addr", 32'(ram_addr), 32'(exp_rd_q.pop_front()));
      end
      if (ram_en && ram_we) begin
         wr_cnt++;
         if (exp_wr_q.size() == 0) check("wr_unexpected", 32'({ram_addr, ram_wdata}), 32'hFFFFF);
         else                      check("wr_strobe", 32'({ram_addr, ram_wdata}), 32'(exp_wr_q.pop_front()));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_pix); #1;
   endtask

   task automatic push_row(input int base);
      for (int k = 0; k < COLS; k++) exp_rd_q.push_back(ADDRW'(base + k));
   endtask

   task automatic trigger(input int s);
      line = 1'b1; sy = CORDW'(s);
      tick();
      line = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_pix);
         if (!busy) break;
      end
      check(tag, 32'(busy), 32'd0);
      tick();
      check({tag, "_left"}, 32'(exp_rd_q.size()), 32'd0);
   endtask

   task automatic read_lb(input string tag, input int col, input logic [CHARW-1:0] exp);
      lb_col = COLW'(col);
      @(posedge clk_pix); @(negedge clk_pix);
      check(tag, 32'(lb_char), 32'(exp));
      tick();
   endtask

   initial begin
      int c;
      // 1: reset
      repeat (3) @(negedge clk_pix);
      check("rst_ctl", 32'({wr_ready, ram_en, ram_we, busy, err_underrun}), 32'd0);
      check("rst_bus", 32'({ram_addr, ram_wdata, lb_char}), 32'd0);
      @(posedge clk_pix); #1; rst_pix_n = 1'b1;
      @(posedge clk_pix); @(negedge clk_pix);
      check("rel_ready", 32'(wr_ready), 32'd1);
      tick();

      // 2: row 0 fetch, then swap and read back
      push_row(0);
      line = 1'b1; sy = -1;
      @(negedge clk_pix);
      check("t2_trig_ready", 32'(wr_ready), 32'd0);
      tick(); line = 1'b0;
      c = 0;
      for (int i = 0; i < 81; i++) begin
         @(negedge clk_pix);
         if (busy && !wr_ready) c++;
      end
      check("t2_busy_cycles", 32'(c), 32'd81);
      @(negedge clk_pix);
      check("t2_idle", 32'({busy, wr_ready}), 32'b01);
      tick();
      check("t2_left", 32'(exp_rd_q.size()), 32'd0);
      trigger(0);
      read_lb("t2_lb5", 5, gold(5));

      // 3: row 1, then non-trigger lines
      push_row(80);
      trigger(15);
      wait_idle("t3_fetch");
      line = 1'b1; sy = 14;
      @(negedge clk_pix); check("t3_sy14_busy", 32'(busy), 32'd0);
      tick(); line = 1'b0;
      @(negedge clk_pix); check("t3_sy14_after", 32'(busy), 32'd0);
      tick();
      line = 1'b1; sy = 479;
      @(negedge clk_pix); check("t3_sy479_busy", 32'(busy), 32'd0);
      tick(); line = 1'b0;
      @(negedge clk_pix); check("t3_sy479_after", 32'(busy), 32'd0);
      tick();
      read_lb("t3_lb3", 3, gold(83));

      // 4: host write held across a fetch
      push_row(160);
      exp_wr_q.push_back({12'd200, 8'h41});
      line = 1'b1; sy = 31; wr_valid = 1'b1; wr_addr = 12'd200; wr_data = 8'h41;
      acc = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_pix);
         if (wr_ready) begin acc = i; break; end
         tick(); line = 1'b0;
      end
      tick(); wr_valid = 1'b0; line = 1'b0;
      check("t4_accept_cycle", 32'(acc), 32'd82);
      repeat (2) tick();
      check("t4_wr_count", 32'(wr_cnt), 32'd1);
      check("t4_ram200", 32'(ram[200]), 32'h41);
      check("t4_left", 32'(exp_rd_q.size()), 32'd0);
      trigger(40);
      read_lb("t4_lb40_prewrite", 40, gold(200));

      // 5: early line pulse aborts a fetch
      push_row(240);
      trigger(47);
      repeat (39) tick();
      line = 1'b1; sy = 0;
      @(negedge clk_pix);
      check("t5_err", 32'({err_underrun, busy}), 32'b11);
      tick(); line = 1'b0;
      @(negedge clk_pix);
      check("t5_after", 32'({err_underrun, busy}), 32'b00);
      tick();
      check("t5_reads_left", 32'(exp_rd_q.size()), 32'd40);
      exp_rd_q.delete();
      check("t5_err_count", 32'(err_cnt), 32'd1);
      read_lb("t5_lb0_flipped", 0, gold(240));

      // 6: reset in the middle of a fetch
      push_row(320);
      trigger(63);
      repeat (30) tick();
      rst_pix_n = 1'b0; #1;
      check("t6_rst_async", 32'({ram_en, busy}), 32'b00);
      @(posedge clk_pix); #2;
      check("t6_reads_left", 32'(exp_rd_q.size()), 32'd50);
      exp_rd_q.delete();
      tick(); rst_pix_n = 1'b1;
      @(negedge clk_pix); check("t6_rel_ready0", 32'(wr_ready), 32'd0);
      @(posedge clk_pix); @(negedge clk_pix); check("t6_rel_ready1", 32'(wr_ready), 32'd1);
      tick();
      push_row(0);
      trigger(-1);
      wait_idle("t6_refetch");
      trigger(0);
      read_lb("t6_lb79", 79, gold(79));
      check("end_err_count", 32'(err_cnt), 32'd1);
      check("end_wr_count", 32'(wr_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
